// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM bus controller and its read cache.
package sram_pkg;

   localparam int unsigned BUS_ADDR_W      = 16;
   localparam int unsigned DATA_W          = 8;
   localparam int unsigned WAIT_CNT_W      = 4;
   localparam int unsigned WAIT_STATES_MAX = 15;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RD     = 3'd1,
      ST_WSETUP = 3'd2,
      ST_WR     = 3'd3,
      ST_ACK    = 3'd4
   } state_e;

endpackage : sram_pkg

// File: rtl/sram_read_cache.sv
// Single-entry last-read cache: valid bit, address and data with a combinational hit compare.
module sram_read_cache
   import sram_pkg::*;
#(
   parameter int unsigned ADDR_W = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [ADDR_W-1:0] lookup_addr_i,
   output logic              hit_c_o,
   output logic [DATA_W-1:0] data_o,
   input  logic              fill_i,
   input  logic [ADDR_W-1:0] fill_addr_i,
   input  logic [DATA_W-1:0] fill_data_i,
   input  logic              upd_i,
   input  logic [ADDR_W-1:0] upd_addr_i,
   input  logic [DATA_W-1:0] upd_data_i
);

   logic              valid_q, valid_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;

   // A completed SRAM read replaces the entry; a write only refreshes data on an address match.
   always_comb begin
      valid_d = valid_q;
      addr_d  = addr_q;
      data_d  = data_q;
      if (fill_i) begin
         valid_d = 1'b1;
         addr_d  = fill_addr_i;
         data_d  = fill_data_i;
      end else if (upd_i && valid_q && (upd_addr_i == addr_q)) begin
         data_d = upd_data_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign hit_c_o = valid_q && (lookup_addr_i == addr_q);
   assign data_o  = data_q;

endmodule : sram_read_cache

// File: rtl/sram_bus_ctrl.sv
// Bus slave converting single cs/we/ack transactions into async SRAM strobe sequences with wait states.
// Optional single-entry read cache enabled by SRAM_BUS_CTRL_READ_CACHE_EN.
module sram_bus_ctrl
   import sram_pkg::*;
#(
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [BUS_ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0]     i_dat,
   output logic [DATA_W-1:0]     o_dat,
   input  logic                  i_cs,
   input  logic                  i_we,
   output logic                  o_ack,
   output logic [ADDR_W-1:0]     o_sram_addr,
   output logic [DATA_W-1:0]     o_sram_dq,
   output logic                  o_sram_dq_oe,
   input  logic [DATA_W-1:0]     i_sram_dq,
   output logic                  o_sram_ce_n,
   output logic                  o_sram_oe_n,
   output logic                  o_sram_we_n
);

   localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);
   localparam logic [WAIT_CNT_W-1:0] CNT_ONE   = WAIT_CNT_W'(1);

   state_e                state_q, state_d;
   logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
   logic                  we_q, we_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [DATA_W-1:0]     dq_q, dq_d;
   logic [DATA_W-1:0]     dat_q, dat_d;
   logic                  ack_q, ack_d;
   logic                  ce_n_q, ce_n_d;
   logic                  oe_n_q, oe_n_d;
   logic                  we_n_q, we_n_d;
   logic                  dq_oe_q, dq_oe_d;

   logic                  cache_hit_c;
   logic [DATA_W-1:0]     cache_data;

`ifdef SRAM_BUS_CTRL_READ_CACHE_EN
   sram_read_cache #(
      .ADDR_W (ADDR_W)
   ) u_cache (
      .clk_i         (i_clk),
      .rst_i         (i_reset),
      .lookup_addr_i (ADDR_W'(i_addr)),
      .hit_c_o       (cache_hit_c),
      .data_o        (cache_data),
      .fill_i        ((state_q == ST_RD) && (cnt_q == '0)),
      .fill_addr_i   (addr_q),
      .fill_data_i   (i_sram_dq),
      .upd_i         ((state_q == ST_ACK) && we_q),
      .upd_addr_i    (addr_q),
      .upd_data_i    (dq_q)
   );
`else
   assign cache_hit_c = 1'b0;
   assign cache_data  = '0;
`endif

   // Next state plus strobes decoded from the next state, so every pin toggles straight off a flop.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      dq_d    = dq_q;
      dat_d   = dat_q;

      case (state_q)
         ST_IDLE: begin
            if (i_cs) begin
               addr_d = ADDR_W'(i_addr);
               dq_d   = i_dat;
               we_d   = i_we;
               cnt_d  = WAIT_LOAD;
               if (i_we) begin
                  state_d = ST_WSETUP;
               end else if (cache_hit_c) begin
                  state_d = ST_ACK;
                  dat_d   = cache_data;
               end else begin
                  state_d = ST_RD;
               end
            end
         end
         ST_RD: begin
            if (cnt_q == '0) begin
               state_d = ST_ACK;
               dat_d   = i_sram_dq;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_WSETUP: begin
            state_d = ST_WR;
            cnt_d   = WAIT_LOAD;
         end
         ST_WR: begin
            if (cnt_q == '0) begin
               state_d = ST_ACK;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_ACK: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      ack_d   = (state_d == ST_ACK);
      ce_n_d  = !((state_d == ST_RD) || (state_d == ST_WSETUP) || (state_d == ST_WR));
      oe_n_d  = (state_d != ST_RD);
      we_n_d  = (state_d != ST_WR);
      // Write data stays driven through ACK to give the SRAM hold time after we_n rises.
      dq_oe_d = (state_d == ST_WSETUP) || (state_d == ST_WR) || ((state_d == ST_ACK) && we_d);
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         dq_q    <= '0;
         dat_q   <= '0;
         ack_q   <= 1'b0;
         ce_n_q  <= 1'b1;
         oe_n_q  <= 1'b1;
         we_n_q  <= 1'b1;
         dq_oe_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         dq_q    <= dq_d;
         dat_q   <= dat_d;
         ack_q   <= ack_d;
         ce_n_q  <= ce_n_d;
         oe_n_q  <= oe_n_d;
         we_n_q  <= we_n_d;
         dq_oe_q <= dq_oe_d;
      end
   end

   assign o_dat        = dat_q;
   assign o_ack        = ack_q;
   assign o_sram_addr  = addr_q;
   assign o_sram_dq    = dq_q;
   assign o_sram_dq_oe = dq_oe_q;
   assign o_sram_ce_n  = ce_n_q;
   assign o_sram_oe_n  = oe_n_q;
   assign o_sram_we_n  = we_n_q;

endmodule : sram_bus_ctrl

// File: tb/tb_sram_bus_ctrl.sv
// Bench for sram_bus_ctrl: two instances (WAIT_STATES=2 and 0) share one bus stimulus.
module tb_sram_bus_ctrl;

   localparam int unsigned WS_A = 2;
   localparam int unsigned WS_B = 0;
`ifdef SRAM_BUS_CTRL_READ_CACHE_EN
   localparam bit CACHE_EN = 1'b1;
`else
   localparam bit CACHE_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        cs, we;
   logic [15:0] addr;
   logic [7:0]  wdat;

   logic [7:0]  dat_a, dq_a, rdq_a, dat_b, dq_b, rdq_b;
   logic [15:0] saddr_a, saddr_b;
   logic        ack_a, oe_a, ce_n_a, oe_n_a, we_n_a;
   logic        ack_b, oe_b, ce_n_b, oe_n_b, we_n_b;

   always #5 clk = ~clk;

   sram_bus_ctrl #(.ADDR_W(16), .WAIT_STATES(WS_A)) u_dut_a (
      .i_clk(clk), .i_reset(rst), .i_addr(addr), .i_dat(wdat), .o_dat(dat_a),
      .i_cs(cs), .i_we(we), .o_ack(ack_a), .o_sram_addr(saddr_a), .o_sram_dq(dq_a),
      .o_sram_dq_oe(oe_a), .i_sram_dq(rdq_a), .o_sram_ce_n(ce_n_a),
      .o_sram_oe_n(oe_n_a), .o_sram_we_n(we_n_a)
   );

   sram_bus_ctrl #(.ADDR_W(16), .WAIT_STATES(WS_B)) u_dut_b (
      .i_clk(clk), .i_reset(rst), .i_addr(addr), .i_dat(wdat), .o_dat(dat_b),
      .i_cs(cs), .i_we(we), .o_ack(ack_b), .o_sram_addr(saddr_b), .o_sram_dq(dq_b),
      .o_sram_dq_oe(oe_b), .i_sram_dq(rdq_b), .o_sram_ce_n(ce_n_b),
      .o_sram_oe_n(oe_n_b), .o_sram_we_n(we_n_b)
   );

   // Behavioural asynchronous SRAMs, one per instance
   logic [7:0] mem_a [0:65535];
   logic [7:0] mem_b [0:65535];
   always @(posedge clk) if (!ce_n_a && !we_n_a && oe_a) mem_a[saddr_a] <= dq_a;
   always @(posedge clk) if (!ce_n_b && !we_n_b && oe_b) mem_b[saddr_b] <= dq_b;
   assign rdq_a = (!ce_n_a && !oe_n_a) ? mem_a[saddr_a] : 8'h00;
   assign rdq_b = (!ce_n_b && !oe_n_b) ? mem_b[saddr_b] : 8'h00;

   // Reference model state: expected memory contents and last-read cache entry
   logic [7:0]  ref_mem [logic [15:0]];
   logic [15:0] wr_q [$];
   bit          c_valid;
   logic [15:0] c_addr;

   int n_pass = 0;
   int n_total = 0;

   int         s_first [2], s_second [2], s_nack [2], s_nwe [2], s_nce [2], s_dbl [2];
   logic [7:0] s_dat [2], s_wdq [2];
   logic       s_prev [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic int exp_lat(input int ws, input bit w, input bit hit);
      if (w) return ws + 3;
      return hit ? 1 : ws + 2;
   endfunction

   task automatic clear_stats();
      for (int k = 0; k < 2; k++) begin
         s_first[k] = 0; s_second[k] = 0; s_nack[k] = 0; s_nwe[k] = 0;
         s_nce[k] = 0; s_dbl[k] = 0; s_dat[k] = 8'h00; s_wdq[k] = 8'h00; s_prev[k] = 1'b0;
      end
   endtask

   task automatic tally(input int k, input int i, input logic ack, input logic ce_n,
                        input logic we_n, input logic oe, input logic [7:0] dat, input logic [7:0] dq);
      if (ack) begin
         if (s_prev[k]) s_dbl[k]++;
         s_nack[k]++;
         if (s_nack[k] == 1) begin s_first[k] = i; s_dat[k] = dat; end
         if (s_nack[k] == 2) s_second[k] = i;
      end
      s_prev[k] = ack;
      if (!ce_n && !we_n && oe) begin s_nwe[k]++; s_wdq[k] = dq; end
      if (!ce_n) s_nce[k]++;
   endtask

   task automatic sample_both(input int i);
      tally(0, i, ack_a, ce_n_a, we_n_a, oe_a, dat_a, dq_a);
      tally(1, i, ack_b, ce_n_b, we_n_b, oe_b, dat_b, dq_b);
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_a_ack"}, ack_a, 0);
      chk({tag, "_a_strobes"}, {ce_n_a, oe_n_a, we_n_a}, 3'b111);
      chk({tag, "_a_dq_oe"}, oe_a, 0);
      chk({tag, "_b_ack"}, ack_b, 0);
      chk({tag, "_b_strobes"}, {ce_n_b, oe_n_b, we_n_b}, 3'b111);
      chk({tag, "_b_dq_oe"}, oe_b, 0);
   endtask

   // One transaction with cs held for a single cycle; called and returning at a negedge.
   task automatic txn(input bit w, input logic [15:0] a, input logic [7:0] d);
      bit hit;
      int ws;
      hit = CACHE_EN && !w && c_valid && (c_addr == a);
      clear_stats();
      cs = 1'b1; we = w; addr = a; wdat = d;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         sample_both(i);
         if (i == 1) begin
            cs = 1'b0; addr = 16'($urandom); wdat = 8'($urandom); we = 1'($urandom);
         end
      end
      for (int k = 0; k < 2; k++) begin
         ws = (k == 0) ? WS_A : WS_B;
         chk($sformatf("ws%0d_%s_%h_ack_count", ws, w ? "wr" : "rd", a), s_nack[k], 1);
         chk($sformatf("ws%0d_%s_%h_latency", ws, w ? "wr" : "rd", a), s_first[k], exp_lat(ws, w, hit));
         chk($sformatf("ws%0d_ack_back_to_back", ws), s_dbl[k], 0);
         chk($sformatf("ws%0d_%s_%h_we_n_cycles", ws, w ? "wr" : "rd", a), s_nwe[k], w ? ws + 1 : 0);
         chk($sformatf("ws%0d_%s_%h_ce_n_cycles", ws, w ? "wr" : "rd", a), s_nce[k],
             hit ? 0 : (w ? ws + 2 : ws + 1));
         chk($sformatf("ws%0d_sram_addr", ws), (k == 0) ? saddr_a : saddr_b, a);
         chk($sformatf("ws%0d_dq_oe_after", ws), (k == 0) ? oe_a : oe_b, 0);
         if (w) chk($sformatf("ws%0d_wr_%h_dq", ws, a), s_wdq[k], d);
         else   chk($sformatf("ws%0d_rd_%h_data", ws, a), s_dat[k], ref_mem[a]);
      end
      if (w) begin
         ref_mem[a] = d;
         wr_q.push_back(a);
      end else begin
         c_valid = 1'b1;
         c_addr  = a;
      end
   endtask

   initial begin
      bit          hit1;
      int          lat1;
      logic [15:0] ra;

      rst = 1'b1; cs = 1'b0; we = 1'b0; addr = 16'h0000; wdat = 8'h00;
      c_valid = 1'b0; c_addr = 16'h0000;
      repeat (2) @(negedge clk);
      chk_quiet("reset");
      chk("reset_a_dat", dat_a, 8'h00);
      chk("reset_a_addr", saddr_a, 16'h0000);
      chk("reset_a_dq", dq_a, 8'h00);
      chk("reset_b_dat", dat_b, 8'h00);
      rst = 1'b0;
      @(negedge clk);

      // Reset while the write strobe is active
      cs = 1'b1; we = 1'b1; addr = 16'h7FFF; wdat = 8'hEE;
      @(negedge clk);
      cs = 1'b0;
      @(negedge clk);
      chk("midwr_a_we_n_active", we_n_a, 0);
      chk("midwr_b_we_n_active", we_n_b, 0);
      #2 rst = 1'b1;
      #1 chk_quiet("midwr_async");
      @(negedge clk);
      rst = 1'b0;
      c_valid = 1'b0;
      clear_stats();
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         sample_both(i);
      end
      chk("midwr_a_no_ack", s_nack[0], 0);
      chk("midwr_b_no_ack", s_nack[1], 0);

      // Directed write/read pair, then the cs-held-high case
      txn(1'b1, 16'h1234, 8'hA5);
      txn(1'b0, 16'h1234, 8'h00);
      txn(1'b1, 16'h0010, 8'h5E);

      hit1 = CACHE_EN && c_valid && (c_addr == 16'h0010);
      lat1 = exp_lat(WS_A, 1'b0, hit1);
      clear_stats();
      cs = 1'b1; we = 1'b0; addr = 16'h0010;
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         sample_both(i);
         if (s_nack[0] >= 2) cs = 1'b0;
      end
      cs = 1'b0;
      repeat (6) @(negedge clk);
      chk("hold_a_ack_count", s_nack[0], 2);
      chk("hold_a_first_ack", s_first[0], lat1);
      chk("hold_a_second_ack", s_second[0], lat1 + 1 + exp_lat(WS_A, 1'b0, CACHE_EN));
      chk("hold_a_data", s_dat[0], ref_mem[16'h0010]);
      chk("hold_a_back_to_back", s_dbl[0], 0);
      chk("hold_b_back_to_back", s_dbl[1], 0);
      c_valid = 1'b1;
      c_addr  = 16'h0010;

      // Repeat reads of one address, then a write to it (cache path when enabled)
      txn(1'b1, 16'h0100, 8'h3C);
      txn(1'b0, 16'h0100, 8'h00);
      txn(1'b0, 16'h0100, 8'h00);
      txn(1'b1, 16'h0100, 8'h77);
      txn(1'b0, 16'h0100, 8'h00);

      // Random traffic against the reference model
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 2) == 0) begin
            txn(1'b1, 16'($urandom), 8'($urandom));
         end else begin
            if (c_valid && ($urandom_range(0, 1) == 0)) ra = c_addr;
            else ra = wr_q[$urandom_range(0, wr_q.size() - 1)];
            txn(1'b0, ra, 8'h00);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_sram_bus_ctrl
